// File: rtl/video_wr_queue.sv
// video_wr_queue
//
// Purpose:
//   Takes CPU write cycles, which are asynchronous to the pixel clock, and
//   queues the ones that target video RAM. The queue drains into the text
//   or attribute RAM whenever the video timing frees a write slot.
//   WR and MREQ are synchronised with two flops each. A third history flop
//   on WR finds the falling edge of a write cycle.
//   Address decode (ADD[15:11]):
//     0xE000..0xE7FF -> attribute RAM (AWE)
//     0xE800..0xEFFF -> text RAM (VWE)
//   Any other address is ignored.
//
// Parameters:
//   DEPTH   number of queue entries (power of two, 2..16)
//
// Ports:
//   pixclk  in   single clock, rising edge
//   rst     in   asynchronous reset, active low
//   DIN     in   [7:0]  CPU data bus
//   ADD     in   [15:0] CPU address bus
//   WR      in   CPU write strobe, active low, asynchronous
//   MREQ    in   CPU memory request, active low, asynchronous
//   wslot   in   video RAM write ports are free this cycle
//   WADD    out  [10:0] video RAM write address
//   WDATA   out  [7:0]  video RAM write data
//   VWE     out  one-cycle text RAM write enable
//   AWE     out  one-cycle attribute RAM write enable
//   full    out  queue holds DEPTH entries
//   empty   out  queue holds no entries
//
// Optional feature (macro VWQ_OVF_EN):
//   ovf     out  sticky flag, set when a write is dropped because the queue is full
//   ovf_clr in   clears ovf; a drop on the same edge wins over the clear

module video_wr_queue #(
  parameter int DEPTH = 4
) (
  input  logic        pixclk,
  input  logic        rst,
  input  logic [7:0]  DIN,
  input  logic [15:0] ADD,
  input  logic        WR,
  input  logic        MREQ,
  input  logic        wslot,
  output logic [10:0] WADD,
  output logic [7:0]  WDATA,
  output logic        VWE,
  output logic        AWE,
  output logic        full,
  output logic        empty
`ifdef VWQ_OVF_EN
  ,
  output logic        ovf,
  input  logic        ovf_clr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Entry layout: {is_text, address[10:0], data[7:0]}
  logic [19:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [19:0]   head;

  logic wr_s1, wr_s2, wr_s3;
  logic mreq_s1, mreq_s2;

  logic detect;
  logic is_attr;
  logic is_text;
  logic push_req;
  logic push;
  logic pop;

  // The synchroniser flops reset to the idle (high) level of the strobes.
  // Then reset release does not look like the start of a write cycle.
  always_ff @(posedge pixclk or negedge rst) begin
    if (!rst) begin
      wr_s1   <= 1'b1;
      wr_s2   <= 1'b1;
      wr_s3   <= 1'b1;
      mreq_s1 <= 1'b1;
      mreq_s2 <= 1'b1;
    end else begin
      wr_s1   <= WR;
      wr_s2   <= wr_s1;
      wr_s3   <= wr_s2;
      mreq_s1 <= MREQ;
      mreq_s2 <= mreq_s1;
    end
  end

  // The falling edge of the synchronised WR, qualified by MREQ, marks the
  // single cycle in which the write is captured.
  assign detect   = ~wr_s2 & wr_s3 & ~mreq_s2;
  assign is_attr  = (ADD[15:11] == 5'b11100);
  assign is_text  = (ADD[15:11] == 5'b11101);
  assign push_req = detect & (is_attr | is_text);

  // The extra pointer bit tells a full queue from an empty one when the
  // index bits are equal.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop  = ~empty & wslot;
  // A pop on the same edge frees a slot, so a full queue can still accept a push.
  assign push = push_req & (~full | pop);

  assign head = mem[rd_ptr[AW-1:0]];

  // The storage needs no reset, because the pointers alone decide what is valid.
  always_ff @(posedge pixclk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {is_text, ADD[10:0], DIN};
    end
  end

  always_ff @(posedge pixclk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // The write port is registered. The enables last one cycle. WADD and WDATA
  // keep their last values until the next pop.
  always_ff @(posedge pixclk or negedge rst) begin
    if (!rst) begin
      WADD  <= '0;
      WDATA <= '0;
      VWE   <= 1'b0;
      AWE   <= 1'b0;
    end else if (pop) begin
      WADD  <= head[18:8];
      WDATA <= head[7:0];
      VWE   <= head[19];
      AWE   <= ~head[19];
    end else begin
      VWE   <= 1'b0;
      AWE   <= 1'b0;
    end
  end

`ifdef VWQ_OVF_EN
  logic drop;

  assign drop = push_req & full & ~pop;

  always_ff @(posedge pixclk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule
